// File: rtl/clock_set_driver.sv
// clock_set_driver
// Drives the alarm clock's setting inputs (Timeset/Alarmset plus the
// Minadv/Hrsadv/Dayadv advance lines) for exactly as many Pulse cycles as are
// needed to move the held value to a target day/hour/minute.
// Optional feature macro: CLOCK_SET_DRIVER_DAY_EN
//   defined   -> DAY phase present, day inputs range-checked
//   undefined -> day advance count forced to 0, Dayadv tied low, day inputs ignored
module clock_set_driver #(
    parameter int NS = 60,   // minute modulus
    parameter int NH = 24,   // hour modulus
    parameter int ND = 7     // day modulus
) (
    input  logic       Pulse,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Mode,
    input  logic [5:0] TgtMin,
    input  logic [5:0] CurMin,
    input  logic [4:0] TgtHrs,
    input  logic [4:0] CurHrs,
    input  logic [2:0] TgtDay,
    input  logic [2:0] CurDay,
    output logic       Timeset,
    output logic       Alarmset,
    output logic       Minadv,
    output logic       Hrsadv,
    output logic       Dayadv,
    output logic       Busy,
    output logic       Done,
    output logic       Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MIN,
        S_HRS,
        S_DAY,
        S_HOLD,
        S_DONE,
        S_ERR
    } state_t;

    state_t     state_q, state_d;
    logic       mode_q, mode_d;
    logic [5:0] min_cnt_q, min_cnt_d;
    logic [4:0] hrs_cnt_q, hrs_cnt_d;
    logic [2:0] day_cnt_q, day_cnt_d;

    logic timeset_q, alarmset_q, minadv_q, hrsadv_q, busy_q, done_q, err_q;

    // Modular differences: subtract with one spare bit, add the modulus back
    // when the borrow bit shows the difference went negative.
    logic [6:0] min_diff;
    logic [5:0] min_mod;
    logic [5:0] hrs_diff;
    logic [4:0] hrs_mod;
    logic [2:0] day_mod;
    logic       min_bad, hrs_bad, day_bad, range_bad;

    assign min_diff = {1'b0, TgtMin} - {1'b0, CurMin};
    assign min_mod  = min_diff[6] ? (min_diff[5:0] + 6'(NS)) : min_diff[5:0];
    assign hrs_diff = {1'b0, TgtHrs} - {1'b0, CurHrs};
    assign hrs_mod  = hrs_diff[5] ? (hrs_diff[4:0] + 5'(NH)) : hrs_diff[4:0];

    assign min_bad  = (TgtMin >= 6'(NS)) || (CurMin >= 6'(NS));
    assign hrs_bad  = (TgtHrs >= 5'(NH)) || (CurHrs >= 5'(NH));

`ifdef CLOCK_SET_DRIVER_DAY_EN
    logic [3:0] day_diff;
    assign day_diff = {1'b0, TgtDay} - {1'b0, CurDay};
    assign day_mod  = day_diff[3] ? (day_diff[2:0] + 3'(ND)) : day_diff[2:0];
    assign day_bad  = (TgtDay >= 3'(ND)) || (CurDay >= 3'(ND));
`else
    // Day inputs are deliberately ignored in this build.
    logic unused_day;
    assign unused_day = ^{TgtDay, CurDay};
    assign day_mod    = 3'd0;
    assign day_bad    = 1'b0;
`endif

    assign range_bad = min_bad || hrs_bad || day_bad;

    // Next-state logic: accept in IDLE/DONE, then walk the non-empty phases.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        min_cnt_d = min_cnt_q;
        hrs_cnt_d = hrs_cnt_q;
        day_cnt_d = day_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (Start) begin
                    mode_d = Mode;
                    if (range_bad) begin
                        state_d   = S_ERR;
                        min_cnt_d = 6'd0;
                        hrs_cnt_d = 5'd0;
                        day_cnt_d = 3'd0;
                    end else begin
                        state_d   = S_SETUP;
                        min_cnt_d = min_mod;
                        hrs_cnt_d = hrs_mod;
                        day_cnt_d = day_mod;
                    end
                end
            end
            S_SETUP: begin
                if (min_cnt_q != 6'd0)      state_d = S_MIN;
                else if (hrs_cnt_q != 5'd0) state_d = S_HRS;
                else if (day_cnt_q != 3'd0) state_d = S_DAY;
                else                        state_d = S_HOLD;
            end
            S_MIN: begin
                min_cnt_d = min_cnt_q - 6'd1;
                if (min_cnt_q == 6'd1) begin
                    if (hrs_cnt_q != 5'd0)      state_d = S_HRS;
                    else if (day_cnt_q != 3'd0) state_d = S_DAY;
                    else                        state_d = S_HOLD;
                end
            end
            S_HRS: begin
                hrs_cnt_d = hrs_cnt_q - 5'd1;
                if (hrs_cnt_q == 5'd1) begin
                    if (day_cnt_q != 3'd0) state_d = S_DAY;
                    else                   state_d = S_HOLD;
                end
            end
            S_DAY: begin
                day_cnt_d = day_cnt_q - 3'd1;
                if (day_cnt_q == 3'd1) state_d = S_HOLD;
            end
            S_HOLD:  state_d = S_DONE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic set_active_d;
    assign set_active_d = (state_d == S_SETUP) || (state_d == S_MIN) || (state_d == S_HRS) ||
                          (state_d == S_DAY)   || (state_d == S_HOLD);

    // State, captured request and registered outputs decoded from the next state.
    always_ff @(posedge Pulse) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            min_cnt_q  <= 6'd0;
            hrs_cnt_q  <= 5'd0;
            day_cnt_q  <= 3'd0;
            timeset_q  <= 1'b0;
            alarmset_q <= 1'b0;
            minadv_q   <= 1'b0;
            hrsadv_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            min_cnt_q  <= min_cnt_d;
            hrs_cnt_q  <= hrs_cnt_d;
            day_cnt_q  <= day_cnt_d;
            timeset_q  <= set_active_d && !mode_d;
            alarmset_q <= set_active_d && mode_d;
            minadv_q   <= (state_d == S_MIN);
            hrsadv_q   <= (state_d == S_HRS);
            busy_q     <= set_active_d;
            done_q     <= (state_d == S_DONE);
            err_q      <= (state_d == S_ERR);
        end
    end

`ifdef CLOCK_SET_DRIVER_DAY_EN
    logic dayadv_q;

    // Day advance line, registered like the others.
    always_ff @(posedge Pulse) begin
        if (Reset) dayadv_q <= 1'b0;
        else       dayadv_q <= (state_d == S_DAY);
    end

    assign Dayadv = dayadv_q;
`else
    assign Dayadv = 1'b0;
`endif

    assign Timeset  = timeset_q;
    assign Alarmset = alarmset_q;
    assign Minadv   = minadv_q;
    assign Hrsadv   = hrsadv_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_clock_set_driver.sv
// Self-checking bench for clock_set_driver: every cycle's output vector
// {Timeset,Alarmset,Minadv,Hrsadv,Dayadv,Busy,Done,Err} is predicted and
// queued when a request is driven, then popped and compared cycle by cycle.
module tb_clock_set_driver;

`ifdef CLOCK_SET_DRIVER_DAY_EN
    localparam bit DAY_EN = 1'b1;
`else
    localparam bit DAY_EN = 1'b0;
`endif

    logic       Pulse = 1'b0;
    logic       Reset, Start, Mode;
    logic [5:0] TgtMin, CurMin;
    logic [4:0] TgtHrs, CurHrs;
    logic [2:0] TgtDay, CurDay;
    logic       Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Busy, Done, Err;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_v, got;

    clock_set_driver dut (
        .Pulse(Pulse), .Reset(Reset), .Start(Start), .Mode(Mode),
        .TgtMin(TgtMin), .CurMin(CurMin), .TgtHrs(TgtHrs), .CurHrs(CurHrs),
        .TgtDay(TgtDay), .CurDay(CurDay),
        .Timeset(Timeset), .Alarmset(Alarmset), .Minadv(Minadv), .Hrsadv(Hrsadv),
        .Dayadv(Dayadv), .Busy(Busy), .Done(Done), .Err(Err)
    );

    always #5 Pulse = ~Pulse;

    function automatic logic [7:0] outv();
        return {Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Busy, Done, Err};
    endfunction

    function automatic int mdiff(input int t, input int c, input int md);
        return (t - c + md) % md;
    endfunction

    // Predict the whole sequence: SETUP, m MIN, h HRS, d DAY, HOLD, DONE.
    task automatic push_run(input bit mode, input int m, input int h, input int d, input bit idle_after);
        int last;
        bit set, ma, ha, da;
        last = m + h + d + 2;
        for (int c = 0; c <= last; c++) begin
            set = (c <= last - 1);
            ma  = (c >= 1) && (c <= m);
            ha  = (c > m) && (c <= m + h);
            da  = (c > m + h) && (c <= m + h + d);
            exp_q.push_back({set && !mode, set && mode, ma, ha, da, set, c == last, 1'b0});
        end
        if (idle_after) exp_q.push_back(8'h00);
    endtask

    task automatic push_case(input bit mode, input int tm, input int th, input int td,
                             input int cm, input int ch, input int cd, input bit idle_after,
                             output int total);
        int m, h, d;
        m = mdiff(tm, cm, 60);
        h = mdiff(th, ch, 24);
        d = DAY_EN ? mdiff(td, cd, 7) : 0;
        total = m + h + d + 2;
        push_run(mode, m, h, d, idle_after);
    endtask

    task automatic drive(input bit mode, input int tm, input int th, input int td,
                         input int cm, input int ch, input int cd);
        Mode   = mode;
        TgtMin = 6'(tm); TgtHrs = 5'(th); TgtDay = 3'(td);
        CurMin = 6'(cm); CurHrs = 5'(ch); CurDay = 3'(cd);
        Start  = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        drive(1'b0, 10, 3, 2, 0, 0, 0);
        for (int k = 0; k < 3; k++) exp_q.push_back(8'h00);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse);
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
        end
        Reset = 1'b0; Start = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse);
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
        end
        $display("tx reset: outputs idle after reset");
    endtask

    task automatic test_time_set();
        int total;
        push_case(1'b0, 59, 7, 0, 0, 0, 0, 1'b1, total);
        drive(1'b0, 59, 7, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse); Start = 1'b0;
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL time_set cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
        end
        $display("tx time_set: 00:00 d0 -> 07:59 d0, done expected at cycle %0d", total);
    endtask

    task automatic test_alarm_set();
        int total;
        push_case(1'b1, 2, 8, 6, 0, 0, 0, 1'b1, total);
        drive(1'b1, 2, 8, 6, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse); Start = 1'b0;
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL alarm_set cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
        end
        $display("tx alarm_set: 00:00 d0 -> 08:02 d6, done expected at cycle %0d", total);
    endtask

    task automatic test_wrap();
        int total;
        push_case(1'b1, 10, 8, 1, 2, 8, 6, 1'b1, total);
        drive(1'b1, 10, 8, 1, 2, 8, 6);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse); Start = 1'b0;
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL wrap cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
        end
        $display("tx wrap: 08:02 d6 -> 08:10 d1, done expected at cycle %0d", total);
    endtask

    // Out-of-range requests: Err for one cycle then idle, no set or advance lines.
    task automatic test_reject();
        int bad [4][7];
        int total;
        bad[0] = '{60, 5, 1, 0, 0, 0, 1};
        bad[1] = '{1, 24, 1, 0, 0, 0, 0};
        bad[2] = '{1, 1, 1, 63, 0, 0, 1};
        bad[3] = '{1, 1, 7, 1, 1, 1, 0};
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && !DAY_EN) begin
                push_case(bad[i][6] != 0, bad[i][0], bad[i][1], bad[i][2],
                          bad[i][3], bad[i][4], bad[i][5], 1'b1, total);
            end else begin
                exp_q.push_back(8'b0000_0001);
                exp_q.push_back(8'h00);
            end
            drive(bad[i][6] != 0, bad[i][0], bad[i][1], bad[i][2], bad[i][3], bad[i][4], bad[i][5]);
            for (int k = 0; exp_q.size() > 0; k++) begin
                @(negedge Pulse); Start = 1'b0;
                exp_v = exp_q.pop_front(); got = outv(); checks++;
                if (got !== exp_v) begin
                    errors++;
                    $display("FAIL reject%0d cyc=%0d got=%b expected=%b", i, k, got, exp_v);
                end
            end
            $display("tx reject%0d: tgt %0d:%0d d%0d cur %0d:%0d d%0d", i,
                     bad[i][1], bad[i][0], bad[i][2], bad[i][4], bad[i][3], bad[i][5]);
        end
    endtask

    task automatic test_equal();
        int total;
        push_case(1'b0, 45, 13, 3, 45, 13, 3, 1'b1, total);
        drive(1'b0, 45, 13, 3, 45, 13, 3);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse); Start = 1'b0;
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL equal cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
        end
        $display("tx equal: 13:45 d3 -> 13:45 d3, done expected at cycle %0d", total);
    endtask

    // Reset sampled at the end of cycle 5 of the time-set case aborts it.
    task automatic test_reset_abort();
        int total;
        push_case(1'b0, 59, 7, 0, 0, 0, 0, 1'b0, total);
        while (exp_q.size() > 6) void'(exp_q.pop_back());
        for (int k = 0; k < 6; k++) exp_q.push_back(8'h00);
        drive(1'b0, 59, 7, 0, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse); Start = 1'b0;
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_abort cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
            if (k == 5) Reset = 1'b1;
            if (k == 6) Reset = 1'b0;
        end
        push_case(1'b1, 3, 1, 1, 0, 0, 0, 1'b1, total);
        drive(1'b1, 3, 1, 1, 0, 0, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse); Start = 1'b0;
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL after_reset cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
        end
        $display("tx reset_abort: aborted at cycle 5, follow-up done expected at cycle %0d", total);
    endtask

    // Start during DONE must begin the next SETUP with no idle gap.
    task automatic test_back_to_back();
        int total_a, total_b;
        push_case(1'b0, 4, 2, 5, 1, 0, 3, 1'b0, total_a);
        push_case(1'b1, 0, 23, 0, 58, 22, 6, 1'b1, total_b);
        drive(1'b0, 4, 2, 5, 1, 0, 3);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse); Start = 1'b0;
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
            if (k == total_a) drive(1'b1, 0, 23, 0, 58, 22, 6);
        end
        $display("tx back_to_back: done at %0d then %0d cycles later", total_a, total_b + 1);
    endtask

    // Start and input churn while busy must not disturb the captured request.
    task automatic test_ignore_inputs();
        int total;
        push_case(1'b0, 5, 2, 1, 3, 1, 0, 1'b1, total);
        drive(1'b0, 5, 2, 1, 3, 1, 0);
        for (int k = 0; exp_q.size() > 0; k++) begin
            @(negedge Pulse); Start = 1'b0;
            exp_v = exp_q.pop_front(); got = outv(); checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL ignore_inputs cyc=%0d got=%b expected=%b", k, got, exp_v);
            end
            if (k < total) begin
                Start  = 1'b1;
                Mode   = 1'($urandom);
                TgtMin = 6'($urandom); CurMin = 6'($urandom);
                TgtHrs = 5'($urandom); CurHrs = 5'($urandom);
                TgtDay = 3'($urandom); CurDay = 3'($urandom);
            end
        end
        $display("tx ignore_inputs: done expected at cycle %0d despite input churn", total);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Mode = 1'b0;
        TgtMin = '0; CurMin = '0; TgtHrs = '0; CurHrs = '0; TgtDay = '0; CurDay = '0;
        @(negedge Pulse);
        test_reset();
        test_time_set();
        test_alarm_set();
        test_wrap();
        test_reject();
        test_equal();
        test_reset_abort();
        test_back_to_back();
        test_ignore_inputs();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
